mmio_axil_master: RTL and testbench

- Single-outstanding bridge from the core's simple MMIO request/response port to an AXI4-Lite master interface (AW/W/B/AR/R).
- Sits directly upstream of the simulation debug peripheral (UART_TX 0x20000000, TIMER 0x20000008, COTRL 0x20000010, COTRL_COREMARK 0x20000020), which it drives.
- Presents AW and W together, as that peripheral requires both valid before it raises either ready.
- Adds a response-wait timeout so a hung slave is flagged instead of silently stalling simulation.

---
 rtl/mmio_axil_master.sv | 195 +++++++++++++++++++
 tb/tb_mmio_axil_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_axil_master.sv
// rtl/mmio_axil_master.sv - single-outstanding MMIO request/response to AXI4-Lite master bridge
// AW and W are issued together; a response-wait timeout forces an error response from a hung slave.
module mmio_axil_master #(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic            REQ_WEN,
    input  logic [AW-1:0]   REQ_ADDR,
    input  logic [DW-1:0]   REQ_WDATA,
    input  logic [DW/8-1:0] REQ_WSTRB,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic [DW-1:0]   RSP_RDATA,
    output logic            RSP_ERR,
    output logic            TIMEOUT_ERR,
    output logic [AW-1:0]   M_AWADDR,
    output logic            M_AWVALID,
    input  logic            M_AWREADY,
    output logic [DW-1:0]   M_WDATA,
    output logic [DW/8-1:0] M_WSTRB,
    output logic            M_WVALID,
    input  logic            M_WREADY,
    input  logic [1:0]      M_BRESP,
    input  logic            M_BVALID,
    output logic            M_BREADY,
    output logic [AW-1:0]   M_ARADDR,
    output logic            M_ARVALID,
    input  logic            M_ARREADY,
    input  logic [DW-1:0]   M_RDATA,
    input  logic [1:0]      M_RRESP,
    input  logic            M_RVALID,
    output logic            M_RREADY
);

    localparam int              SW         = DW / 8;
    localparam int              CW         = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit              TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0]   CNT_LAST   = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WB,
        S_RD_A,
        S_RD_R,
        S_RSP
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            wen_q, wen_d;
    logic            awv_q, awv_d;
    logic            wv_q, wv_d;
    logic            arv_q, arv_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            tmo_q, tmo_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wen_q   <= 1'b0;
            awv_q   <= 1'b0;
            wv_q    <= 1'b0;
            arv_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            wen_q   <= wen_d;
            awv_q   <= awv_d;
            wv_q    <= wv_d;
            arv_q   <= arv_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        wen_d   = wen_q;
        awv_d   = awv_q;
        wv_d    = wv_q;
        arv_d   = arv_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                    wstrb_d = REQ_WSTRB;
                    wen_d   = REQ_WEN;
                    if (REQ_WEN) begin
                        state_d = S_WR;
                        awv_d   = 1'b1;
                        wv_d    = 1'b1;
                    end else begin
                        state_d = S_RD_A;
                        arv_d   = 1'b1;
                    end
                end
            end
            S_WR: begin
                // Each channel retires independently; leave only once both have handshaken.
                if (awv_q && M_AWREADY) awv_d = 1'b0;
                if (wv_q && M_WREADY)   wv_d  = 1'b0;
                if (!awv_d && !wv_d) begin
                    state_d = S_WB;
                    cnt_d   = '0;
                end
            end
            S_WB: begin
                if (M_BVALID) begin
                    err_d   = (M_BRESP != 2'b00);
                    rdata_d = '0;
                    state_d = S_RSP;
                end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                    state_d = S_RSP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RD_A: begin
                if (M_ARREADY) begin
                    arv_d   = 1'b0;
                    state_d = S_RD_R;
                    cnt_d   = '0;
                end
            end
            S_RD_R: begin
                if (M_RVALID) begin
                    rdata_d = M_RDATA;
                    err_d   = (M_RRESP != 2'b00);
                    state_d = S_RSP;
                end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                    state_d = S_RSP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RSP: begin
                if (RSP_READY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All handshake outputs come from flops, so no request input reaches the AXI side combinationally.
    assign REQ_READY   = (state_q == S_IDLE);
    assign RSP_VALID   = (state_q == S_RSP);
    assign RSP_RDATA   = wen_q ? '0 : rdata_q;
    assign RSP_ERR     = err_q;
    assign TIMEOUT_ERR = tmo_q;
    assign M_AWADDR    = addr_q;
    assign M_AWVALID   = awv_q;
    assign M_WDATA     = wdata_q;
    assign M_WSTRB     = wstrb_q;
    assign M_WVALID    = wv_q;
    assign M_BREADY    = (state_q == S_WB);
    assign M_ARADDR    = addr_q;
    assign M_ARVALID   = arv_q;
    assign M_RREADY    = (state_q == S_RD_R);

endmodule

// File: tb/tb_mmio_axil_master.sv
// tb/tb_mmio_axil_master.sv - directed self-checking bench for mmio_axil_master
module tb_mmio_axil_master;

    logic        CLK, RSTn;
    logic        REQ_VALID, REQ_READY, REQ_WEN;
    logic [31:0] REQ_ADDR;
    logic [63:0] REQ_WDATA;
    logic [7:0]  REQ_WSTRB;
    logic        RSP_VALID, RSP_READY, RSP_ERR, TIMEOUT_ERR;
    logic [63:0] RSP_RDATA;
    logic [31:0] M_AWADDR, M_ARADDR;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
    logic [63:0] M_WDATA, M_RDATA;
    logic [7:0]  M_WSTRB;
    logic [1:0]  M_BRESP, M_RRESP;
    logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_axil_master #(.AW(32), .DW(64), .TIMEOUT(16)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WEN(REQ_WEN),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .TIMEOUT_ERR(TIMEOUT_ERR),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [63:0] data);
        REQ_VALID = 1'b1; REQ_WEN = wen; REQ_ADDR = addr; REQ_WDATA = data; REQ_WSTRB = 8'hFF;
        step();
        REQ_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        REQ_VALID = 0; REQ_WEN = 0; REQ_ADDR = 0; REQ_WDATA = 0; REQ_WSTRB = 0; RSP_READY = 0;
        M_AWREADY = 0; M_WREADY = 0; M_BRESP = 0; M_BVALID = 0;
        M_ARREADY = 0; M_RDATA = 0; M_RRESP = 0; M_RVALID = 0;
        step(); step();
        n_cmp++; if (REQ_READY !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", REQ_READY); end
        n_cmp++; if ({M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY} !== 5'b0) begin
            n_bad++; $display("FAIL rst_m_ctrl: got %b want 00000", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}); end
        n_cmp++; if ({RSP_VALID, RSP_ERR, TIMEOUT_ERR} !== 3'b0) begin
            n_bad++; $display("FAIL rst_rsp_flags: got %b want 000", {RSP_VALID, RSP_ERR, TIMEOUT_ERR}); end
        n_cmp++; if (RSP_RDATA !== 64'h0 || M_AWADDR !== 32'h0 || M_WDATA !== 64'h0 || M_WSTRB !== 8'h0) begin
            n_bad++; $display("FAIL rst_regs: got rdata %h awaddr %h wdata %h wstrb %h want all 0", RSP_RDATA, M_AWADDR, M_WDATA, M_WSTRB); end
        RSTn = 1'b1;
        step();
    endtask

    task automatic test_write_basic();
        int vcyc = 0;
        issue(1'b1, 32'h2000_0000, 64'h41);
        n_cmp++; if (M_AWADDR !== 32'h2000_0000 || M_WDATA !== 64'h41 || M_WSTRB !== 8'hFF) begin
            n_bad++; $display("FAIL wr_fields: got %h %h %h want 20000000 41 ff", M_AWADDR, M_WDATA, M_WSTRB); end
        if (M_AWVALID && M_WVALID) vcyc++;
        step();
        if (M_AWVALID && M_WVALID) vcyc++;
        M_AWREADY = 1; M_WREADY = 1;
        step();
        M_AWREADY = 0; M_WREADY = 0;
        if (M_AWVALID || M_WVALID) vcyc++;
        n_cmp++; if (vcyc !== 2) begin n_bad++; $display("FAIL wr_valid_cycles: got %0d want 2", vcyc); end
        n_cmp++; if (M_BREADY !== 1'b1) begin n_bad++; $display("FAIL wr_bready: got %b want 1", M_BREADY); end
        M_BVALID = 1; M_BRESP = 2'b00;
        step();
        M_BVALID = 0;
        n_cmp++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || RSP_RDATA !== 64'h0 || M_BREADY !== 1'b0 || REQ_READY !== 1'b0) begin
            n_bad++; $display("FAIL wr_rsp: got valid %b err %b rdata %h bready %b req_ready %b want 1 0 0 0 0",
                              RSP_VALID, RSP_ERR, RSP_RDATA, M_BREADY, REQ_READY); end
        RSP_READY = 1;
        step();
        RSP_READY = 0;
        n_cmp++; if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
            n_bad++; $display("FAIL wr_back_idle: got req_ready %b rsp_valid %b want 1 0", REQ_READY, RSP_VALID); end
    endtask

    task automatic test_write_stagger();
        issue(1'b1, 32'h2000_0010, 64'h1122_3344_5566_7788);
        M_AWREADY = 1;
        step();
        M_AWREADY = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (M_AWVALID !== 1'b0 || M_WVALID !== 1'b1 || M_BREADY !== 1'b0) begin
                n_bad++; $display("FAIL stag_hold%0d: got awv %b wv %b bready %b want 0 1 0", i, M_AWVALID, M_WVALID, M_BREADY); end
            if (i == 2) M_WREADY = 1;
            step();
        end
        M_WREADY = 0;
        n_cmp++; if (M_WVALID !== 1'b0 || M_BREADY !== 1'b1) begin
            n_bad++; $display("FAIL stag_wb: got wv %b bready %b want 0 1", M_WVALID, M_BREADY); end
        M_BVALID = 1; M_BRESP = 2'b00;
        step();
        n_cmp++; if (RSP_VALID !== 1'b1 || M_BREADY !== 1'b0) begin
            n_bad++; $display("FAIL stag_one_b: got rsp_valid %b bready %b want 1 0", RSP_VALID, M_BREADY); end
        step();
        M_BVALID = 0;
        n_cmp++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || M_BREADY !== 1'b0) begin
            n_bad++; $display("FAIL stag_rsp: got valid %b err %b bready %b want 1 0 0", RSP_VALID, RSP_ERR, M_BREADY); end
        RSP_READY = 1;
        step();
        RSP_READY = 0;
        step();
    endtask

    task automatic test_read(input logic [1:0] rresp, input logic [63:0] rdata, input logic exp_err);
        issue(1'b0, 32'h2000_0008, 64'h0);
        n_cmp++; if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'h2000_0008 || M_AWVALID !== 1'b0) begin
            n_bad++; $display("FAIL rd_ar: got arv %b araddr %h awv %b want 1 20000008 0", M_ARVALID, M_ARADDR, M_AWVALID); end
        M_ARREADY = 1;
        step();
        M_ARREADY = 0;
        n_cmp++; if (M_ARVALID !== 1'b0 || M_RREADY !== 1'b1) begin
            n_bad++; $display("FAIL rd_rready: got arv %b rready %b want 0 1", M_ARVALID, M_RREADY); end
        M_RVALID = 1; M_RDATA = rdata; M_RRESP = rresp;
        step();
        M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== rdata || RSP_ERR !== exp_err || M_RREADY !== 1'b0) begin
                n_bad++; $display("FAIL rd_rsp%0d: got valid %b rdata %h err %b rready %b want 1 %h %b 0",
                                  i, RSP_VALID, RSP_RDATA, RSP_ERR, M_RREADY, rdata, exp_err); end
            step();
        end
        n_cmp++; if (TIMEOUT_ERR !== 1'b0) begin n_bad++; $display("FAIL rd_tmo_flag: got %b want 0", TIMEOUT_ERR); end
        RSP_READY = 1;
        step();
        RSP_READY = 0;
        n_cmp++; if (REQ_READY !== 1'b1) begin n_bad++; $display("FAIL rd_back_idle: got %b want 1", REQ_READY); end
    endtask

    task automatic test_timeout();
        int early = 0;
        issue(1'b1, 32'h2000_0000, 64'h42);
        M_AWREADY = 1; M_WREADY = 1;
        step();
        M_AWREADY = 0; M_WREADY = 0;
        for (int i = 1; i < 16; i++) begin
            step();
            if (RSP_VALID || !M_BREADY) early++;
        end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL tmo_early: got %0d early cycles want 0", early); end
        step();
        n_cmp++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_RDATA !== 64'h0 || TIMEOUT_ERR !== 1'b1 || M_BREADY !== 1'b0) begin
            n_bad++; $display("FAIL tmo_rsp: got valid %b err %b rdata %h tmo %b bready %b want 1 1 0 1 0",
                              RSP_VALID, RSP_ERR, RSP_RDATA, TIMEOUT_ERR, M_BREADY); end
        M_BVALID = 1;
        step();
        n_cmp++; if (M_BREADY !== 1'b0) begin n_bad++; $display("FAIL tmo_late_b_accepted: got bready %b want 0", M_BREADY); end
        RSP_READY = 1;
        step();
        RSP_READY = 0;
        n_cmp++; if (M_BREADY !== 1'b0 || REQ_READY !== 1'b1) begin
            n_bad++; $display("FAIL tmo_late_b_idle: got bready %b req_ready %b want 0 1", M_BREADY, REQ_READY); end
        M_BVALID = 0;
        issue(1'b0, 32'h2000_0020, 64'h0);
        M_ARREADY = 1;
        step();
        M_ARREADY = 0; M_RVALID = 1; M_RDATA = 64'h1234; M_RRESP = 0;
        step();
        M_RVALID = 0; M_RDATA = 0;
        n_cmp++; if (RSP_RDATA !== 64'h1234 || RSP_ERR !== 1'b0 || TIMEOUT_ERR !== 1'b1) begin
            n_bad++; $display("FAIL tmo_sticky: got rdata %h err %b tmo %b want 1234 0 1", RSP_RDATA, RSP_ERR, TIMEOUT_ERR); end
        RSP_READY = 1;
        step();
        RSP_READY = 0;
    endtask

    task automatic test_timeout_edge();
        issue(1'b1, 32'h2000_0000, 64'h43);
        M_AWREADY = 1; M_WREADY = 1;
        step();
        M_AWREADY = 0; M_WREADY = 0;
        repeat (15) step();
        n_cmp++; if (RSP_VALID !== 1'b0 || M_BREADY !== 1'b1) begin
            n_bad++; $display("FAIL edge_pre: got rsp_valid %b bready %b want 0 1", RSP_VALID, M_BREADY); end
        M_BVALID = 1; M_BRESP = 2'b00;
        step();
        M_BVALID = 0;
        n_cmp++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0) begin
            n_bad++; $display("FAIL edge_handshake_wins: got valid %b err %b want 1 0", RSP_VALID, RSP_ERR); end
        RSP_READY = 1;
        step();
        RSP_READY = 0;
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 32'h2000_0000, 64'h44);
        M_AWREADY = 1; M_WREADY = 1;
        step();
        M_AWREADY = 0; M_WREADY = 0;
        n_cmp++; if (M_BREADY !== 1'b1) begin n_bad++; $display("FAIL mid_in_wb: got bready %b want 1", M_BREADY); end
        #2 RSTn = 1'b0;
        #1;
        n_cmp++; if ({M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, RSP_VALID, TIMEOUT_ERR} !== 6'b0 || REQ_READY !== 1'b1) begin
            n_bad++; $display("FAIL mid_wb_rst: got %b req_ready %b want 000000 1",
                              {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, RSP_VALID, TIMEOUT_ERR}, REQ_READY); end
        step();
        RSTn = 1'b1;
        step();
        issue(1'b0, 32'h2000_0008, 64'h0);
        n_cmp++; if (M_ARVALID !== 1'b1) begin n_bad++; $display("FAIL mid_in_rda: got arvalid %b want 1", M_ARVALID); end
        #2 RSTn = 1'b0;
        #1;
        n_cmp++; if (M_ARVALID !== 1'b0 || M_RREADY !== 1'b0 || RSP_VALID !== 1'b0) begin
            n_bad++; $display("FAIL mid_rda_rst: got arv %b rready %b rsp_valid %b want 0 0 0", M_ARVALID, M_RREADY, RSP_VALID); end
        step();
        RSTn = 1'b1;
        step();
        n_cmp++; if (REQ_READY !== 1'b1) begin n_bad++; $display("FAIL mid_release: got req_ready %b want 1", REQ_READY); end
        test_write_basic();
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_stagger();
        test_read(2'b00, 64'hDEAD_BEEF_0000_0001, 1'b0);
        test_read(2'b10, 64'h0000_0000_CAFE_F00D, 1'b1);
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
